// File: rtl/serial_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : serial_slave_port
// Brief    : Bit-serial bus responder bridging a master to a synchronous RAM.
// Revision : 1.0  initial release
// ============================================================================
module serial_slave_port #(
  parameter int ADDR_LEN        = 12,
  parameter int DATA_LEN        = 8,
  parameter int BURST_LEN       = 12,
  parameter int SPLIT_THRESHOLD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          slave_delay,
  input  logic                read_en,
  input  logic                write_en,
  input  logic                master_valid,
  input  logic                master_ready,
  input  logic                rx_address,
  input  logic                rx_burst,
  input  logic                rx_data,
  output logic                slave_ready,
  output logic                slave_valid,
  output logic                tx_data,
  output logic                split_en,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic                slave_done
);

  localparam int CNT_W = $clog2((ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN) + 1;

  localparam logic [CNT_W-1:0]     c_addr_last = CNT_W'(ADDR_LEN - 1);
  localparam logic [CNT_W-1:0]     c_data_last = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0]     c_burst_len = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]     c_cnt_one   = CNT_W'(1);
  localparam logic [BURST_LEN-1:0] c_one_word  = BURST_LEN'(1);
  localparam logic [ADDR_LEN-1:0]  c_addr_one  = ADDR_LEN'(1);
  localparam logic [5:0]           c_split_th  = 6'(SPLIT_THRESHOLD);
  localparam bit                   c_split_ok  = (SPLIT_THRESHOLD <= 63);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_WR_RX    = 3'd2,
    S_WR_MEM   = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD_REQ   = 3'd5,
    S_RD_LATCH = 3'd6,
    S_RD_TX    = 3'd7
  } state_t;

  state_t              state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [ADDR_LEN-1:0] addr_q,   addr_d;
  logic [BURST_LEN-1:0] burst_q, burst_d;
  logic                rd_mode_q, rd_mode_d;
  logic [DATA_LEN-1:0] wshift_q, wshift_d;
  logic [DATA_LEN-1:0] rshift_q, rshift_d;
  logic [DATA_LEN-1:0] wdata_q,  wdata_d;
  logic [5:0]          dly_q,    dly_d;
  logic                split_q,  split_d;
  logic                done_q,   done_d;
  logic                ready_q,  ready_d;
  logic                valid_q,  valid_d;
  logic                we_q,     we_d;
  logic                re_q,     re_d;

  logic                 w_beat;
  logic [BURST_LEN-1:0] w_burst_shift;
  logic [BURST_LEN-1:0] w_burst_cap;
  logic [BURST_LEN-1:0] w_burst_words;

  // Address and burst arrive LSB first, so both shift right with the new bit
  // entering at the top; after the full phase bit 0 holds the first beat.
  assign w_beat        = master_valid & ready_q;
  assign w_burst_shift = {rx_burst, burst_q[BURST_LEN-1:1]};
  assign w_burst_cap   = (cnt_q < c_burst_len) ? w_burst_shift : burst_q;
  assign w_burst_words = (w_burst_cap == '0) ? c_one_word : w_burst_cap;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    rd_mode_d = rd_mode_q;
    wshift_d  = wshift_q;
    rshift_d  = rshift_q;
    wdata_d   = wdata_q;
    dly_d     = dly_q;
    split_d   = split_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_beat && (read_en ^ write_en)) begin
          rd_mode_d = read_en;
          addr_d    = {rx_address, addr_q[ADDR_LEN-1:1]};
          burst_d   = w_burst_cap;
          cnt_d     = c_cnt_one;
          state_d   = S_ADDR;
        end
      end

      S_ADDR: begin
        if (w_beat) begin
          addr_d  = {rx_address, addr_q[ADDR_LEN-1:1]};
          burst_d = w_burst_cap;
          cnt_d   = cnt_q + c_cnt_one;
          if (cnt_q == c_addr_last) begin
            cnt_d   = '0;
            burst_d = w_burst_words;
            if (!rd_mode_q) begin
              state_d = S_WR_RX;
            end else if (slave_delay == 6'd0) begin
              state_d = S_RD_REQ;
            end else begin
              dly_d   = slave_delay;
              split_d = c_split_ok && (slave_delay >= c_split_th);
              state_d = S_RD_WAIT;
            end
          end
        end
      end

      S_WR_RX: begin
        if (w_beat) begin
          wshift_d = {rx_data, wshift_q[DATA_LEN-1:1]};
          cnt_d    = cnt_q + c_cnt_one;
          if (cnt_q == c_data_last) begin
            cnt_d   = '0;
            wdata_d = wshift_d;
            done_d  = (burst_q == c_one_word);
            state_d = S_WR_MEM;
          end
        end
      end

      S_WR_MEM: begin
        addr_d = addr_q + c_addr_one;
        if (burst_q == c_one_word) begin
          state_d = S_IDLE;
        end else begin
          burst_d = burst_q - c_one_word;
          state_d = S_WR_RX;
        end
      end

      S_RD_WAIT: begin
        if (dly_q <= 6'd1) begin
          split_d = 1'b0;
          state_d = S_RD_REQ;
        end else begin
          dly_d = dly_q - 6'd1;
        end
      end

      S_RD_REQ: begin
        state_d = S_RD_LATCH;
      end

      S_RD_LATCH: begin
        rshift_d = mem_rdata;
        cnt_d    = '0;
        state_d  = S_RD_TX;
      end

      S_RD_TX: begin
        if (master_ready) begin
          rshift_d = {1'b0, rshift_q[DATA_LEN-1:1]};
          cnt_d    = cnt_q + c_cnt_one;
          if (cnt_q == c_data_last) begin
            cnt_d  = '0;
            addr_d = addr_q + c_addr_one;
            if (burst_q == c_one_word) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              burst_d = burst_q - c_one_word;
              state_d = S_RD_REQ;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered from the next state so they line up with it.
    ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WR_RX);
    we_d    = (state_d == S_WR_MEM);
    re_d    = (state_d == S_RD_REQ);
    valid_d = (state_d == S_RD_TX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      rd_mode_q <= 1'b0;
      wshift_q  <= '0;
      rshift_q  <= '0;
      wdata_q   <= '0;
      dly_q     <= '0;
      split_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      rd_mode_q <= rd_mode_d;
      wshift_q  <= wshift_d;
      rshift_q  <= rshift_d;
      wdata_q   <= wdata_d;
      dly_q     <= dly_d;
      split_q   <= split_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      we_q      <= we_d;
      re_q      <= re_d;
    end
  end

  // The read shifter fills with zeros, so tx_data idles low between words.
  assign slave_ready = ready_q;
  assign slave_valid = valid_q;
  assign tx_data     = rshift_q[0];
  assign split_en    = split_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = we_q;
  assign mem_re      = re_q;
  assign slave_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_slave_port.sv
`default_nettype none
// Randomised scoreboard bench for serial_slave_port against a RAM reference.
module tb_serial_slave_port;

  localparam int AL = 12;
  localparam int DL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    slave_delay;
  logic          read_en, write_en, master_valid, master_ready;
  logic          rx_address, rx_burst, rx_data;
  logic          slave_ready, slave_valid, tx_data, split_en;
  logic [AL-1:0] mem_addr;
  logic [DL-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re, slave_done;

  serial_slave_port #(
    .ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(12), .SPLIT_THRESHOLD(8)
  ) dut (
    .clk(clk), .reset(reset), .slave_delay(slave_delay),
    .read_en(read_en), .write_en(write_en),
    .master_valid(master_valid), .master_ready(master_ready),
    .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
    .split_en(split_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .slave_done(slave_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM attached to the DUT, preloaded with a fixed pattern on the first edge.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 37 + 11);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  // Reference contents as the master believes them to be.
  logic [7:0] ref_mem [0:4095];
  logic [7:0] wbuf [0:15];

  typedef struct { logic [11:0] a; logic [7:0] d; int cyc; bit last; } wexp_t;
  typedef struct { logic [11:0] a; int cyc; int split; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];
  bit    tq[$];
  wexp_t we_e;
  rexp_t re_e;

  int checks = 0, passes = 0;
  int done_seen = 0, done_exp = 0;
  int split_run = 0;
  bit pv = 0, pr = 0, ptx = 0, alt_tog = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    checks++;
    $display("FAIL %s: event not expected (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (reset) split_run = 0;
    if (split_en) split_run++;
    if (mem_we) begin
      if (wq.size() == 0) fail_now("unexpected_mem_we");
      else begin
        we_e = wq.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(we_e.a));
        check("wr_data", 32'(mem_wdata), 32'(we_e.d));
        if (we_e.cyc >= 0) check("wr_cycle", cyc, we_e.cyc);
        check("wr_done_on_last", 32'(slave_done), 32'(we_e.last));
      end
    end
    if (mem_re) begin
      if (rq.size() == 0) fail_now("unexpected_mem_re");
      else begin
        re_e = rq.pop_front();
        check("rd_addr", 32'(mem_addr), 32'(re_e.a));
        check("split_cycles", split_run, re_e.split);
        if (re_e.cyc >= 0) check("rd_cycle", cyc, re_e.cyc);
      end
      split_run = 0;
    end
    if (slave_valid && master_ready) begin
      if (tq.size() == 0) fail_now("unexpected_tx_bit");
      else check("tx_bit", 32'(tx_data), 32'(tq.pop_front()));
    end
    if (pv && !pr && slave_valid) check("tx_hold", 32'(tx_data), 32'(ptx));
    if (slave_done) done_seen++;
    pv  = slave_valid;
    pr  = master_ready;
    ptx = tx_data;
  end

  // One beat: present the bits until the DUT accepts them.
  task automatic drive_beat(input bit a, input bit b, input bit d, input int vmode,
                            input bit first, output int acc_cyc);
    int n = 0;
    bit stall, fin = 0;
    acc_cyc = cyc;
    while (!fin) begin
      @(posedge clk); #1;
      stall = (vmode == 1) ? alt_tog : (vmode == 2) ? ($urandom_range(0, 99) < 30) : 1'b0;
      alt_tog = ~alt_tog;
      master_valid = !stall;
      rx_address = a; rx_burst = b; rx_data = d;
      if (!first) begin read_en = 1'($urandom); write_en = 1'($urandom); end
      if (!stall && slave_ready) begin
        fin = 1; acc_cyc = cyc;
      end else if (++n > 200) begin
        fail_now("beat_timeout"); fin = 1;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(slave_ready), 32'd1);
    check({tag, "_valid"}, 32'(slave_valid), 32'd0);
    check({tag, "_tx"},    32'(tx_data), 32'd0);
    check({tag, "_split"}, 32'(split_en), 32'd0);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_re"},    32'(mem_re), 32'd0);
    check({tag, "_done"},  32'(slave_done), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic txn(input bit is_rd, input logic [11:0] addr, input logic [11:0] burst,
                     input logic [5:0] dly, input int vmode, input int rmode);
    int nw, c0, c, tmo, vcnt;
    logic [11:0] wa;
    logic [7:0]  rv;
    nw = (burst == 0) ? 1 : int'(burst);
    slave_delay = dly; master_ready = 1'b1;
    read_en = is_rd; write_en = !is_rd;
    drive_beat(addr[0], burst[0], 1'b0, vmode, 1'b1, c0);
    for (int w = 0; w < nw; w++) begin
      wa = addr + 12'(w);
      if (!is_rd) begin
        wq.push_back('{wa, wbuf[w], (vmode == 0) ? c0 + AL + DL * (w + 1) + w : -1, w == nw - 1});
        ref_mem[wa] = wbuf[w];
      end else begin
        rq.push_back('{wa, (vmode == 0 && (w == 0 || rmode == 0)) ? c0 + AL + int'(dly) + 10 * w : -1,
                       (w == 0 && dly >= 6'd8) ? int'(dly) : 0});
        rv = ref_mem[wa];
        for (int b = 0; b < DL; b++) tq.push_back(rv[b]);
      end
    end
    done_exp++;
    for (int i = 1; i < AL; i++) drive_beat(addr[i], burst[i], 1'b0, vmode, 1'b0, c);
    if (!is_rd)
      for (int w = 0; w < nw; w++)
        for (int b = 0; b < DL; b++) drive_beat(1'b0, 1'b0, wbuf[w][b], vmode, 1'b0, c);
    tmo = 0; vcnt = 0;
    while (1) begin
      @(posedge clk); #1;
      master_valid = 1'b0;
      if (slave_done) break;
      if (slave_valid) vcnt++;
      master_ready = (rmode == 1) ? !(vcnt >= 3 && vcnt < 6) :
                     (rmode == 2) ? ($urandom_range(0, 99) >= 30) : 1'b1;
      if (++tmo > 3000) begin fail_now("done_timeout"); break; end
    end
    master_ready = 1'b1;
    @(negedge clk); #1;
    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);
    check("tq_drained", tq.size(), 0);
    check("done_count", done_seen, done_exp);
    wq.delete(); rq.delete(); tq.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 37 + 11);
    reset = 1'b1; slave_delay = '0; read_en = 0; write_en = 0;
    master_valid = 0; master_ready = 1; rx_address = 0; rx_burst = 0; rx_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;

    wbuf[0] = 8'hA5;
    txn(1'b0, 12'h005, 12'd1, 6'd0, 0, 0);
    txn(1'b1, 12'h005, 12'd1, 6'd0, 0, 0);
    txn(1'b1, 12'h123, 12'd1, 6'd10, 0, 0);
    txn(1'b1, 12'h124, 12'd1, 6'd7, 0, 0);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    txn(1'b0, 12'hFFE, 12'd3, 6'd0, 0, 0);
    txn(1'b1, 12'hFFE, 12'd3, 6'd2, 0, 1);
    wbuf[0] = 8'h5A;
    txn(1'b0, 12'h005, 12'd1, 6'd0, 1, 0);
    txn(1'b1, 12'h005, 12'd0, 6'd0, 0, 1);

    // Both enables, then neither: must stay idle without strobes.
    @(posedge clk); #1;
    read_en = 1; write_en = 1; master_valid = 1; rx_address = 1; rx_burst = 1;
    repeat (4) begin @(posedge clk); #1; check("illegal_both_ready", 32'(slave_ready), 32'd1); end
    read_en = 0; write_en = 0;
    repeat (4) begin @(posedge clk); #1; check("illegal_none_ready", 32'(slave_ready), 32'd1); end
    master_valid = 0;

    // Abort a write during its data phase.
    read_en = 0; write_en = 1; slave_delay = '0;
    for (int i = 0; i < AL; i++) drive_beat(i == 8, i == 0, 1'b0, 0, i == 0, c);
    for (int b = 0; b < 3; b++) drive_beat(1'b0, 1'b0, 1'b1, 0, 1'b0, c);
    @(posedge clk); #1;
    reset = 1'b1; master_valid = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals("abort");
    repeat (30) @(posedge clk);

    for (int t = 0; t < 40; t++) begin
      logic [11:0] a, bl;
      bit rd;
      rd = 1'($urandom);
      a  = 12'($urandom);
      bl = 12'($urandom_range(0, 4));
      for (int w = 0; w < 16; w++) wbuf[w] = 8'($urandom);
      txn(rd, a, bl, 6'($urandom_range(0, 20)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
Responder end of the serial bus protocol driven by master_module through Bus_interconnect. It deserialises the address, burst count and write data arriving one bit per handshake. It then drives a parallel synchronous memory port, and serialises read data back to the master. One instance sits between each interconnect slave port (sN_*) and a block RAM. It supports bursts, programmable read latency and split signalling.

Parameters:
ADDR_LEN, 12, address width in bits (serial address phase length)
DATA_LEN, 8, data word width in bits
BURST_LEN, 12, burst count width; must be <= ADDR_LEN
SPLIT_THRESHOLD, 8, slave_delay value at or above which split_en is raised during the read wait

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
slave_delay  in  6  read wait cycles inserted before the first word of each read burst
read_en  in  1  read transaction request (qualified by master_valid)
write_en  in  1  write transaction request (qualified by master_valid)
master_valid  in  1  master drives a valid bit on rx_address/rx_burst/rx_data
master_ready  in  1  master accepts the current tx_data bit
rx_address  in  1  serial address, LSB first
rx_burst  in  1  serial burst count, LSB first
rx_data  in  1  serial write data, LSB first
slave_ready  out  1  slave accepts an incoming bit this cycle
slave_valid  out  1  tx_data carries a valid read bit
tx_data  out  1  serial read data, LSB first
split_en  out  1  slave requests a bus split during a long read wait
mem_addr  out  ADDR_LEN  memory address
mem_wdata  out  DATA_LEN  memory write data
mem_we  out  1  memory write strobe, 1 cycle
mem_re  out  1  memory read strobe, 1 cycle; mem_rdata valid the following cycle
mem_rdata  in  DATA_LEN  memory read data
slave_done  out  1  1-cycle pulse when the last word of a transaction completes

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE and all counters clear.
  - slave_ready=1; slave_valid, tx_data, split_en, mem_we, mem_re, slave_done=0; mem_addr, mem_wdata=0.
  - Reset asserted mid-transaction aborts it; no further mem_we or mem_re is issued.
- Beat: a cycle in which master_valid && slave_ready are both high. All outputs are registered.
- IDLE (slave_ready=1):
  - A beat with exactly one of read_en or write_en high starts a transaction, and that beat carries address bit 0. The mode is latched on that beat.
  - A beat with both enables high, or with neither, is ignored and the block stays in IDLE.
- ADDR (slave_ready=1):
  - Runs ADDR_LEN beats in total, counting the IDLE beat.
  - rx_address bit i is captured on beat i. rx_burst bit i is captured on beat i for i < BURST_LEN.
  - master_valid low stalls the phase without losing state.
  - Word count = burst value, except burst value 0 means 1 word.
  - After the last address beat, go to WR_RX (write) or RD_WAIT (read).
- WR_RX (slave_ready=1):
  - Shifts in DATA_LEN beats of rx_data, LSB first.
  - On the DATA_LEN-th beat, go to WR_MEM.
- WR_MEM (1 cycle, slave_ready=0):
  - mem_we=1, with mem_wdata = the assembled word and mem_addr = the current address.
  - Then increment the address modulo 2^ADDR_LEN, so 0xFFF wraps to 0x000.
  - If words remain, return to WR_RX; otherwise pulse slave_done and go to IDLE.
- RD_WAIT (slave_ready=0):
  - Loads a counter with slave_delay and counts down; delay 0 means zero cycles here.
  - split_en=1 throughout RD_WAIT when slave_delay >= SPLIT_THRESHOLD, and 0 otherwise.
  - On reaching 0, go to RD_REQ.
- RD_REQ (1 cycle): mem_re=1 with the current mem_addr.
- RD_LATCH (1 cycle): capture mem_rdata into the shift register.
- RD_TX:
  - slave_valid=1 and tx_data = shift bit 0.
  - Each cycle with master_ready=1 shifts one bit.
  - After DATA_LEN accepted bits, slave_valid drops and the address increments (same wrap rule as writes).
  - If words remain, go to RD_REQ; the wait is not re-inserted. Otherwise pulse slave_done and go to IDLE.
- read_en/write_en changes after the start beat are ignored until the block returns to IDLE.
- Minimum latency, write of 1 word: ADDR_LEN + DATA_LEN beats, then 1 WR_MEM cycle.
- Minimum latency, read of 1 word: ADDR_LEN beats, slave_delay, 2 cycles, then DATA_LEN bits.

Test Plan:
1. Write, addr 0x005, burst 1, data 0xA5, master_valid held high:
   - mem_we pulses exactly once, 20 cycles after the first beat, with mem_addr=0x005 and mem_wdata=0xA5.
   - slave_done pulses in the same cycle.
2. Read, addr 0x005, slave_delay=0, mem_rdata=0xA5, master_ready high:
   - mem_re pulses once with mem_addr=0x005.
   - tx_data serialises 1,0,1,0,0,1,0,1 with slave_valid=1 for 8 cycles.
   - split_en stays 0.
3. Read, slave_delay=10:
   - split_en=1 for exactly 10 cycles, then mem_re pulses.
   - With slave_delay=7, split_en stays 0.
4. Write burst of 3 words starting at addr 0xFFE, data 0x11, 0x22, 0x33:
   - mem_we pulses at 0xFFE, 0xFFF, 0x000 with those data.
   - slave_done pulses once.
5. Stalls:
   - master_valid toggled low every other cycle during ADDR/WR_RX produces a result identical to scenario 1.
   - master_ready low 3 cycles mid-RD_TX holds tx_data stable.
6. Illegal start and reset:
   - read_en=write_en=1 in IDLE keeps the block in IDLE with no strobes.
   - reset asserted in WR_RX leaves the block in IDLE with all outputs at reset values next cycle, and no mem_we occurs.
